// File: rtl/master_in_port.sv
// Serial-to-parallel receiver: takes an LSB-first bit stream after an s_valid/m_ready
// handshake and holds each rebuilt word in a one-entry valid/ready output buffer.
module master_in_port #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  s_valid,
    input  logic                  rx_data,
    input  logic                  s_tx_done,
    output logic                  m_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  frame_err,
    output logic [CNT_WIDTH-1:0]  rx_count
);

    localparam int BCW = $clog2(DATA_WIDTH) + 1;

    typedef enum logic {
        IDLE = 1'b0,
        RX   = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [BCW-1:0]        bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic                  out_valid_q, out_valid_d;
    logic                  frame_err_q, frame_err_d;
    logic [CNT_WIDTH-1:0]  rx_count_q, rx_count_d;

    // Ready is purely registered so the slave never sees a comb loop through us.
    assign m_ready   = (state_q == IDLE) && !out_valid_q;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign frame_err = frame_err_q;
    assign rx_count  = rx_count_q;

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        frame_err_d = 1'b0;
        rx_count_d  = rx_count_q;

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (s_valid && m_ready) begin
                    state_d   = RX;
                    bit_cnt_d = '0;
                end
            end
            RX: begin
                shift_d[bit_cnt_q] = rx_data;
                bit_cnt_d          = bit_cnt_q + BCW'(1);
                if (bit_cnt_q == BCW'(DATA_WIDTH - 1)) begin
                    // The last bit bypasses the shift register straight into the buffer.
                    out_data_d  = {rx_data, shift_q[DATA_WIDTH-2:0]};
                    out_valid_d = 1'b1;
                    frame_err_d = !s_tx_done;
                    rx_count_d  = rx_count_q + CNT_WIDTH'(1);
                    bit_cnt_d   = '0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
            rx_count_q  <= '0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            frame_err_q <= frame_err_d;
            rx_count_q  <= rx_count_d;
        end
    end

endmodule

// File: tb/tb_master_in_port.sv
// Directed bench for master_in_port; a second instance with a 2-bit counter exercises counter wrap.
module tb_master_in_port;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        s_valid = 1'b0;
    logic        rx_data = 1'b0;
    logic        s_tx_done = 1'b0;
    logic        out_ready = 1'b0;
    logic        m_ready, out_valid, frame_err;
    logic [7:0]  out_data;
    logic [15:0] rx_count;
    logic        m_ready2, out_valid2, frame_err2;
    logic [7:0]  out_data2;
    logic [1:0]  rx_count2;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    master_in_port #(.DATA_WIDTH(8), .CNT_WIDTH(16)) dut (
        .clk(clk), .rst(rst), .s_valid(s_valid), .rx_data(rx_data),
        .s_tx_done(s_tx_done), .m_ready(m_ready), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready), .frame_err(frame_err),
        .rx_count(rx_count)
    );

    master_in_port #(.DATA_WIDTH(8), .CNT_WIDTH(2)) dut_wrap (
        .clk(clk), .rst(rst), .s_valid(s_valid), .rx_data(rx_data),
        .s_tx_done(s_tx_done), .m_ready(m_ready2), .out_data(out_data2),
        .out_valid(out_valid2), .out_ready(out_ready), .frame_err(frame_err2),
        .rx_count(rx_count2)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Entered and left at #1 after a posedge; on return the final bit has just been sampled.
    task automatic send_frame(input logic [7:0] w, input logic ok, input logic hold,
                              output time hs_t);
        int n;
        n = 0;
        s_valid = 1'b1;
        while (!m_ready && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        chk("handshake_timeout", {31'd0, m_ready}, 32'd1);
        @(posedge clk);
        hs_t = $time;
        #1;
        s_valid = hold;
        for (int i = 0; i < 8; i++) begin
            rx_data   = w[i];
            s_tx_done = (i == 7) ? ok : 1'b0;
            @(posedge clk); #1;
        end
        rx_data   = 1'b0;
        s_tx_done = 1'b0;
    endtask

    typedef struct {
        logic [7:0]  word;
        logic        ok;
        logic [7:0]  exp_data;
        logic        exp_err;
        logic [15:0] exp_cnt;
        logic [1:0]  exp_cnt2;
    } vec_t;

    vec_t vecs[5];
    time  t0, t1;

    initial begin
        vecs[0] = '{8'hA5, 1'b1, 8'hA5, 1'b0, 16'd1, 2'd1};
        vecs[1] = '{8'h3C, 1'b1, 8'h3C, 1'b0, 16'd2, 2'd2};
        vecs[2] = '{8'hFF, 1'b0, 8'hFF, 1'b1, 16'd3, 2'd3};
        vecs[3] = '{8'h00, 1'b1, 8'h00, 1'b0, 16'd4, 2'd0};
        vecs[4] = '{8'h5A, 1'b0, 8'h5A, 1'b1, 16'd5, 2'd1};

        #12;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_data", {24'd0, out_data}, 32'd0);
        chk("rst_frame_err", {31'd0, frame_err}, 32'd0);
        chk("rst_rx_count", {16'd0, rx_count}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        chk("rst_m_ready", {31'd0, m_ready}, 32'd1);

        // Table: receive with the buffer blocked, inspect, then drain one cycle.
        for (int v = 0; v < 5; v++) begin
            out_ready = 1'b0;
            send_frame(vecs[v].word, vecs[v].ok, 1'b0, t0);
            chk($sformatf("v%0d_out_valid", v), {31'd0, out_valid}, 32'd1);
            chk($sformatf("v%0d_out_data", v), {24'd0, out_data}, {24'd0, vecs[v].exp_data});
            chk($sformatf("v%0d_frame_err", v), {31'd0, frame_err}, {31'd0, vecs[v].exp_err});
            chk($sformatf("v%0d_rx_count", v), {16'd0, rx_count}, {16'd0, vecs[v].exp_cnt});
            chk($sformatf("v%0d_rx_count_wrap", v), {30'd0, rx_count2}, {30'd0, vecs[v].exp_cnt2});
            chk($sformatf("v%0d_m_ready_busy", v), {31'd0, m_ready}, 32'd0);
            out_ready = 1'b1;
            @(posedge clk); #1;
            chk($sformatf("v%0d_drained", v), {31'd0, out_valid}, 32'd0);
            chk($sformatf("v%0d_err_pulse", v), {31'd0, frame_err}, 32'd0);
            chk($sformatf("v%0d_m_ready_back", v), {31'd0, m_ready}, 32'd1);
        end

        // Backpressure: s_valid held high while the buffer is full.
        out_ready = 1'b0;
        send_frame(8'h3C, 1'b1, 1'b1, t0);
        chk("bp_data", {24'd0, out_data}, 32'h3C);
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            chk($sformatf("bp_m_ready_%0d", k), {31'd0, m_ready}, 32'd0);
            chk($sformatf("bp_hold_%0d", k), {24'd0, out_data}, 32'h3C);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_valid", {31'd0, out_valid}, 32'd0);
        chk("bp_release_ready", {31'd0, m_ready}, 32'd1);
        out_ready = 1'b0;
        send_frame(8'h96, 1'b1, 1'b0, t0);
        chk("bp_next_data", {24'd0, out_data}, 32'h96);
        chk("bp_next_count", {16'd0, rx_count}, 32'd7);
        out_ready = 1'b1;
        @(posedge clk); #1;

        // Asynchronous reset after five bits of 0x81.
        out_ready = 1'b0;
        s_valid = 1'b1;
        @(posedge clk); #1;
        s_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            rx_data = i[0] ? 1'b0 : (i == 0);
            @(posedge clk); #1;
        end
        #2;
        rst = 1'b1;
        #1;
        chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("arst_out_data", {24'd0, out_data}, 32'd0);
        chk("arst_frame_err", {31'd0, frame_err}, 32'd0);
        chk("arst_rx_count", {16'd0, rx_count}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        chk("arst_m_ready", {31'd0, m_ready}, 32'd1);
        for (int k = 0; k < 10; k++) begin
            rx_data = k[0];
            @(posedge clk); #1;
            chk($sformatf("arst_no_valid_%0d", k), {31'd0, out_valid}, 32'd0);
        end
        chk("arst_count_kept", {16'd0, rx_count}, 32'd0);

        // Back-to-back with the consumer always ready.
        out_ready = 1'b1;
        send_frame(8'h01, 1'b1, 1'b1, t0);
        chk("b2b_first_valid", {31'd0, out_valid}, 32'd1);
        chk("b2b_first_data", {24'd0, out_data}, 32'h01);
        send_frame(8'h80, 1'b1, 1'b1, t1);
        chk("b2b_second_data", {24'd0, out_data}, 32'h80);
        chk("b2b_period", (t1 - t0) / 10, 32'd10);
        chk("b2b_count", {16'd0, rx_count}, 32'd2);

        // Two more frames take the 2-bit counter from 3 to 0.
        send_frame(8'hC3, 1'b1, 1'b1, t0);
        chk("wrap_pre", {30'd0, rx_count2}, 32'd3);
        send_frame(8'h7E, 1'b1, 1'b0, t0);
        chk("wrap_count", {30'd0, rx_count2}, 32'd0);
        chk("wrap_data", {24'd0, out_data2}, 32'h7E);
        chk("wrap_wide_count", {16'd0, rx_count}, 32'd4);
        @(posedge clk); #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
